weights_bank_sequencer: RTL and testbench
=========================================

// Module: weights_bank_sequencer
// PURPOSE
//  Sole master of the weight register bank's control/address/data pins. Shares the bank
//  between the AMBA write path (weight loading) and the neuron datapath (row fetch bursts).
//  Streams fetched weight rows to the datapath through a 2-entry skid buffer with ready/valid.
// PARAMETERS
//  Amba_Addr_Depth  12  bank holds 2**Amba_Addr_Depth rows; address ports are Amba_Addr_Depth+1 bits
//  WeightPrecision  5   bits per weight (5/8/16)
//  WeightRowWidth   15  bits per row = 3*WeightPrecision
// PORTS
//  clock        in   1    single clock, all logic on posedge
//  reset        in   1    synchronous, active-high
//  wr_req       in   1    AMBA side requests a row write
//  wr_addr      in   AD+1 row address for write (AD = Amba_Addr_Depth)
//  wr_data      in   RW   row data for write (RW = WeightRowWidth)
//  wr_ack       out  1    1-cycle pulse: write issued to bank this cycle
//  fetch_start  in   1    1-cycle pulse: begin fetch burst
//  fetch_base   in   AD+1 first row address
//  fetch_len    in   AD+1 number of rows, 0..2**AD
//  busy         out  1    burst in progress (FETCH or DRAIN)
//  done         out  1    1-cycle pulse: last row of burst accepted by consumer
//  row_data     out  RW   weight row to datapath
//  row_valid    out  1    row_data valid
//  row_ready    in   1    datapath accepts row when row_valid&row_ready
//  bank_control out  2    to bank: 2'b01 WRITE, 2'b10 READ, 2'b00 idle
//  bank_address out  AD+1 to bank address
//  bank_wdata   out  RW   to bank write data
//  bank_rdata   in   RW   from bank; valid exactly 1 cycle after READ issued, else may be z
// BEHAVIOUR
//  Reset: all outputs 0 (bank_control=00, wr_ack=0, busy=0, done=0, row_valid=0); FSM->IDLE;
//   skid buffer emptied; in-flight read flag cleared. Reset mid-burst aborts it, no done pulse.
//  Bank interface registered: bank_control/address/wdata change only on clock edge.
//  FSM: IDLE -> FETCH on fetch_start (len>0); IDLE -> DONE on fetch_start with len=0 (no reads);
//   FETCH -> DRAIN after final READ issued; DRAIN -> DONE when last row handshaken; DONE -> IDLE
//   after 1 cycle with done=1.
//  Arbitration: writes granted only in IDLE and DONE; bursts are atomic. In IDLE, wr_req has
//   priority over a same-cycle fetch_start: write issues, fetch_start is latched (pending) and
//   burst begins next cycle. fetch_start while busy is ignored. wr_ack=1 the cycle bank_control=01.
//  Read issue rule: issue READ at addr cur only if (buffer occupancy + in-flight) < 2.
//   Bank data captured into buffer the cycle after READ (in-flight flag set then cleared).
//   bank_rdata sampled only when in-flight flag set.
//  Address: cur = fetch_base, increments by 1 per READ, wraps modulo 2**AD; bank_address MSB=0
//   on reads. Write address passed through unchanged.
//  Throughput: with row_ready held 1, one row per cycle; first row_valid 2 cycles after
//   fetch_start (READ issue, capture). row_ready low stalls reads; no row lost or duplicated.
//  Row counter width AD+1 so fetch_len=2**AD is legal (full bank sweep).
//  Skid buffer: rows delivered in address order; row_data held stable while valid&!ready.
// STRUCTURE
//  Shared package/header: bank opcodes (WRITE=2'b01, READ=2'b10, IDLE=2'b00), FSM state
//   encodings (IDLE, FETCH, DRAIN, DONE).
//  Sub-module: weight_row_skid_buffer (2-entry FIFO, RW wide, occupancy output, sync reset).
//  Top: FSM, arbiter, address/row counters, in-flight flag, registered bank outputs.
// TESTING
//  1 Write then fetch: wr_req addr 5 data 15'h1234 -> wr_ack, bank_control=01; fetch base 5
//    len 1 -> row_data=15'h1234 two cycles after start, done pulse on handshake.
//  2 Burst len 4 base 10, row_ready=1 -> rows addr 10..13 on 4 consecutive cycles, done once.
//  3 Backpressure: len 6, row_ready toggles 1,0,0,1... -> all 6 rows in order, never >2
//    outstanding, no READ issued when buffer+inflight=2.
//  4 Wrap: base 4094 len 4 (AD=12) -> addresses 4094,4095,0,1; bank_address MSB=0.
//  5 Collisions: wr_req+fetch_start same IDLE cycle -> write first, burst next cycle;
//    wr_req during FETCH -> no wr_ack until DONE; fetch_start while busy ignored.
//  6 Edge: len 0 -> done 1 cycle later, no READ; reset asserted mid-burst (row 3 of 8) ->
//    all outputs 0 next cycle, buffer empty, no done pulse, new burst works after reset drops.

Source files
------------

// File: rtl/weights_bank_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : weights_bank_sequencer_pkg
//  Purpose  : Bank opcodes and sequencer state encodings shared by the
//             weight bank sequencer and its sub-blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package weights_bank_sequencer_pkg;

    localparam logic [1:0] c_BANK_IDLE  = 2'b00;
    localparam logic [1:0] c_BANK_WRITE = 2'b01;
    localparam logic [1:0] c_BANK_READ  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage : weights_bank_sequencer_pkg
`default_nettype wire

// File: rtl/weights_bank_sequencer_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : weight_row_skid_buffer
//  Purpose  : Two-entry FIFO between bank read capture and the row consumer.
//             Output is taken straight from storage so it holds while stalled.
//  Revision : 1.0 - initial release
// ============================================================================
module weight_row_skid_buffer #(
    parameter int WIDTH = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic w_do_push;
    logic w_do_pop;

    always_comb begin
        w_do_pop  = pop && (r_count != 2'd0);
        // A full buffer still accepts a push when the head leaves this cycle.
        w_do_push = push && ((r_count != 2'd2) || w_do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_data  = r_mem[r_rd_ptr];
    assign out_valid = (r_count != 2'd0);
    assign occupancy = r_count;

endmodule : weight_row_skid_buffer
`default_nettype wire

// File: rtl/weights_bank_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : weights_bank_sequencer
//  Purpose  : Sole master of the weight bank pins; arbitrates AMBA row writes
//             against atomic row-fetch bursts streamed out through a skid buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module weights_bank_sequencer
    import weights_bank_sequencer_pkg::*;
#(
    parameter int AMBA_ADDR_DEPTH  = 12,
    parameter int WEIGHT_PRECISION = 5,
    parameter int WEIGHT_ROW_WIDTH = 3 * WEIGHT_PRECISION
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr_req,
    input  logic [AMBA_ADDR_DEPTH:0]    wr_addr,
    input  logic [WEIGHT_ROW_WIDTH-1:0] wr_data,
    output logic                        wr_ack,
    input  logic                        fetch_start,
    input  logic [AMBA_ADDR_DEPTH:0]    fetch_base,
    input  logic [AMBA_ADDR_DEPTH:0]    fetch_len,
    output logic                        busy,
    output logic                        done,
    output logic [WEIGHT_ROW_WIDTH-1:0] row_data,
    output logic                        row_valid,
    input  logic                        row_ready,
    output logic [1:0]                  bank_control,
    output logic [AMBA_ADDR_DEPTH:0]    bank_address,
    output logic [WEIGHT_ROW_WIDTH-1:0] bank_wdata,
    input  logic [WEIGHT_ROW_WIDTH-1:0] bank_rdata
);

    localparam int AD = AMBA_ADDR_DEPTH;
    localparam int RW = WEIGHT_ROW_WIDTH;

    localparam logic [AD:0]   c_ONE_ROW  = (AD+1)'(1);
    localparam logic [AD-1:0] c_ONE_ADDR = AD'(1);

    seq_state_t     r_state;
    logic [AD-1:0]  r_cur;
    logic [AD:0]    r_rd_left;
    logic [AD:0]    r_rows_left;
    logic           r_inflight;
    logic           r_pend;
    logic [AD:0]    r_pend_base;
    logic [AD:0]    r_pend_len;

    logic [1:0]     r_bank_control;
    logic [AD:0]    r_bank_address;
    logic [RW-1:0]  r_bank_wdata;
    logic           r_wr_ack;
    logic           r_busy;
    logic           r_done;

    logic           w_row_valid;
    logic [1:0]     w_occ;
    logic           w_pop;
    logic [2:0]     w_slots;
    logic           w_wr_grant;
    logic [AD:0]    w_start_base;
    logic [AD:0]    w_start_len;
    logic           w_unused;

    weight_row_skid_buffer #(
        .WIDTH (RW)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (r_inflight),
        .push_data (bank_rdata),
        .pop       (w_pop),
        .out_data  (row_data),
        .out_valid (w_row_valid),
        .occupancy (w_occ)
    );

    always_comb begin
        w_pop        = w_row_valid && row_ready;
        // Slots committed at the next edge: stored rows plus the row in flight,
        // less the one leaving now. A new READ is allowed while this is below 2.
        w_slots      = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_start_base = r_pend ? r_pend_base : fetch_base;
        w_start_len  = r_pend ? r_pend_len  : fetch_len;
        // Holding off one cycle after an ack keeps a level-held wr_req from
        // being written twice.
        w_wr_grant   = wr_req && !r_wr_ack &&
                       (((r_state == ST_IDLE) && !r_pend) || (r_state == ST_DONE));
        w_unused     = w_start_base[AD];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cur          <= '0;
            r_rd_left      <= '0;
            r_rows_left    <= '0;
            r_inflight     <= 1'b0;
            r_pend         <= 1'b0;
            r_pend_base    <= '0;
            r_pend_len     <= '0;
            r_bank_control <= c_BANK_IDLE;
            r_bank_address <= '0;
            r_bank_wdata   <= '0;
            r_wr_ack       <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_bank_control <= c_BANK_IDLE;
            r_bank_address <= '0;
            r_bank_wdata   <= '0;
            r_wr_ack       <= 1'b0;
            r_done         <= 1'b0;
            r_inflight     <= 1'b0;

            if (w_pop) begin
                r_rows_left <= r_rows_left - c_ONE_ROW;
            end

            if (w_wr_grant) begin
                r_bank_control <= c_BANK_WRITE;
                r_bank_address <= wr_addr;
                r_bank_wdata   <= wr_data;
                r_wr_ack       <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_pend || (fetch_start && !w_wr_grant)) begin
                        r_pend <= 1'b0;
                        if (w_start_len == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            // First READ goes out on the start edge itself.
                            r_bank_control <= c_BANK_READ;
                            r_bank_address <= {1'b0, w_start_base[AD-1:0]};
                            r_inflight     <= 1'b1;
                            r_cur          <= w_start_base[AD-1:0] + c_ONE_ADDR;
                            r_rd_left      <= w_start_len - c_ONE_ROW;
                            r_rows_left    <= w_start_len;
                            r_busy         <= 1'b1;
                            r_state        <= ST_FETCH;
                        end
                    end else if (fetch_start) begin
                        r_pend      <= 1'b1;
                        r_pend_base <= fetch_base;
                        r_pend_len  <= fetch_len;
                    end
                end
                ST_FETCH: begin
                    if (r_rd_left == '0) begin
                        r_state <= ST_DRAIN;
                    end else if (w_slots < 3'd2) begin
                        r_bank_control <= c_BANK_READ;
                        r_bank_address <= {1'b0, r_cur};
                        r_inflight     <= 1'b1;
                        r_cur          <= r_cur + c_ONE_ADDR;
                        r_rd_left      <= r_rd_left - c_ONE_ROW;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && (r_rows_left == c_ONE_ROW)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (fetch_start) begin
                        r_pend      <= 1'b1;
                        r_pend_base <= fetch_base;
                        r_pend_len  <= fetch_len;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_ack       = r_wr_ack;
    assign busy         = r_busy;
    assign done         = r_done;
    assign row_valid    = w_row_valid;
    assign bank_control = r_bank_control;
    assign bank_address = r_bank_address;
    assign bank_wdata   = r_bank_wdata;

endmodule : weights_bank_sequencer
`default_nettype wire

// File: tb/tb_weights_bank_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_weights_bank_sequencer
//  Purpose  : Scoreboard bench for the weight bank sequencer with a bank model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_weights_bank_sequencer;

    localparam int AD = 12;
    localparam int RW = 15;

    logic          clock = 1'b0;
    logic          reset;
    logic          wr_req;
    logic [AD:0]   wr_addr;
    logic [RW-1:0] wr_data;
    logic          wr_ack;
    logic          fetch_start;
    logic [AD:0]   fetch_base;
    logic [AD:0]   fetch_len;
    logic          busy;
    logic          done;
    logic [RW-1:0] row_data;
    logic          row_valid;
    logic          row_ready;
    logic [1:0]    bank_control;
    logic [AD:0]   bank_address;
    logic [RW-1:0] bank_wdata;
    logic [RW-1:0] bank_rdata;

    always #5 clock = ~clock;

    weights_bank_sequencer #(
        .AMBA_ADDR_DEPTH  (AD),
        .WEIGHT_PRECISION (5),
        .WEIGHT_ROW_WIDTH (RW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .fetch_start  (fetch_start),
        .fetch_base   (fetch_base),
        .fetch_len    (fetch_len),
        .busy         (busy),
        .done         (done),
        .row_data     (row_data),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .bank_control (bank_control),
        .bank_address (bank_address),
        .bank_wdata   (bank_wdata),
        .bank_rdata   (bank_rdata)
    );

    // Bank model: write on the edge, read data visible the cycle READ is presented.
    logic [RW-1:0] mem [0:(1<<AD)-1];
    initial begin
        for (int i = 0; i < (1 << AD); i++) mem[i] = RW'((i * 37 + 11) ^ (i >> 3));
    end
    always @(posedge clock) begin
        if (bank_control == 2'b01) mem[bank_address[AD-1:0]] <= bank_wdata;
    end
    assign bank_rdata = (bank_control == 2'b10) ? mem[bank_address[AD-1:0]] : '0;

    logic [RW-1:0]    q_row  [$];
    logic [AD:0]      q_addr [$];
    logic [AD+RW:0]   q_wr   [$];

    int n_cmp  = 0;
    int n_fail = 0;
    int n_reads = 0;
    int n_acc   = 0;
    int n_done  = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a bank op or a row.
    always @(negedge clock) begin
        if (reset) begin
            n_acc = n_reads;
        end else begin
            chk("wr_ack_vs_write", 32'(wr_ack), 32'(bank_control == 2'b01));
            if (bank_control == 2'b10) begin
                chk("rd_addr_msb", 32'(bank_address[AD]), 32'd0);
                if (q_addr.size() == 0) chk("rd_unexpected", 32'(bank_address), 32'hFFFF_FFFF);
                else chk("rd_addr", 32'(bank_address), 32'(q_addr.pop_front()));
                n_reads++;
            end
            if (bank_control == 2'b01) begin
                if (q_wr.size() == 0) chk("wr_unexpected", 32'(bank_address), 32'hFFFF_FFFF);
                else chk("wr_addr_data", 32'({bank_address, bank_wdata}), 32'(q_wr.pop_front()));
            end
            if (busy) chk("outstanding_le2", 32'((n_reads - n_acc) <= 2), 32'd1);
            if (row_valid && row_ready) begin
                if (q_row.size() == 0) chk("row_unexpected", 32'(row_data), 32'hFFFF_FFFF);
                else chk("row_data", 32'(row_data), 32'(q_row.pop_front()));
                n_acc++;
            end
            if (done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_burst(input int base, input int len);
        for (int i = 0; i < len; i++) begin
            int a;
            a = (base + i) % (1 << AD);
            q_addr.push_back((AD+1)'(a));
            q_row.push_back(mem[a]);
        end
    endtask

    task automatic pulse_fetch(input int base, input int len);
        fetch_start = 1'b1;
        fetch_base  = (AD+1)'(base);
        fetch_len   = (AD+1)'(len);
        tick();
        fetch_start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name, input logic bp);
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        while (!done && k < bound) begin
            if (bp) row_ready = pat[k % 4];
            tick();
            k++;
        end
        chk(name, 32'(done), 32'd1);
        row_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int k;
        logic prev_done;

        reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        fetch_start = 1'b0; fetch_base = '0; fetch_len = '0; row_ready = 1'b1;
        repeat (2) tick();
        chk("rst_bank_control", 32'(bank_control), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_row_valid", 32'(row_valid), 32'd0);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        reset = 1'b0;
        tick();

        // 1: write then single-row fetch
        q_wr.push_back({13'd5, 15'h1234});
        wr_req = 1'b1; wr_addr = 13'd5; wr_data = 15'h1234;
        tick();
        wr_req = 1'b0;
        chk("t1_wr_ack", 32'(wr_ack), 32'd1);
        chk("t1_bank_write", 32'(bank_control), 32'd1);
        q_addr.push_back(13'd5); q_row.push_back(15'h1234);
        d0 = n_done;
        pulse_fetch(5, 1);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_row_valid", 32'(row_valid), 32'd1);
        chk("t1_row_data", 32'(row_data), 32'h1234);
        tick();
        chk("t1_done", 32'(done), 32'd1);
        tick();
        chk("t1_done_once", 32'(n_done - d0), 32'd1);

        // 2: len 4 burst streams one row per cycle
        exp_burst(10, 4);
        d0 = n_done;
        pulse_fetch(10, 4);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_stream_valid", 32'(row_valid), 32'd1);
            tick();
        end
        chk("t2_done", 32'(done), 32'd1);
        tick();
        chk("t2_done_once", 32'(n_done - d0), 32'd1);

        // 3: backpressure pattern 1,0,0,1
        exp_burst(40, 6);
        d0 = n_done;
        pulse_fetch(40, 6);
        wait_done(80, "t3_done", 1'b1);
        tick();
        chk("t3_done_once", 32'(n_done - d0), 32'd1);
        chk("t3_rows_all_seen", 32'(q_row.size()), 32'd0);

        // 4: address wrap
        exp_burst(4094, 4);
        d0 = n_done;
        pulse_fetch(4094, 4);
        wait_done(30, "t4_done", 1'b0);
        tick();
        chk("t4_done_once", 32'(n_done - d0), 32'd1);
        chk("t4_addrs_all_seen", 32'(q_addr.size()), 32'd0);

        // 5a: write and fetch in the same idle cycle
        q_wr.push_back({13'd100, 15'h5a5a});
        q_addr.push_back(13'd100); q_row.push_back(15'h5a5a);
        q_addr.push_back(13'd101); q_row.push_back(mem[101]);
        wr_req = 1'b1; wr_addr = 13'd100; wr_data = 15'h5a5a;
        fetch_start = 1'b1; fetch_base = 13'd100; fetch_len = 13'd2;
        tick();
        wr_req = 1'b0; fetch_start = 1'b0;
        chk("t5_write_first", 32'(bank_control), 32'd1);
        chk("t5_not_busy_yet", 32'(busy), 32'd0);
        tick();
        chk("t5_read_next", 32'(bank_control), 32'd2);
        chk("t5_busy", 32'(busy), 32'd1);
        wait_done(20, "t5a_done", 1'b0);
        tick();

        // 5b: write held off and fetch ignored while a burst runs
        exp_burst(20, 4);
        d0 = n_done;
        pulse_fetch(20, 4);
        q_wr.push_back({13'd7, 15'h0abc});
        wr_req = 1'b1; wr_addr = 13'd7; wr_data = 15'h0abc;
        fetch_start = 1'b1; fetch_base = 13'd50; fetch_len = 13'd3;
        k = 0;
        prev_done = 1'b0;
        while (!wr_ack && k < 30) begin
            prev_done = done;
            tick();
            if (k == 0) fetch_start = 1'b0;
            k++;
        end
        wr_req = 1'b0;
        chk("t5_wr_ack_seen", 32'(wr_ack), 32'd1);
        chk("t5_ack_after_done", 32'(prev_done), 32'd1);
        repeat (3) tick();
        chk("t5_done_once", 32'(n_done - d0), 32'd1);
        chk("t5_fetch_ignored", 32'(busy), 32'd0);
        chk("t5_no_extra_reads", 32'(q_addr.size()), 32'd0);

        // 6a: zero-length burst
        d0 = n_done;
        pulse_fetch(0, 0);
        chk("t6_len0_done", 32'(done), 32'd1);
        chk("t6_len0_busy", 32'(busy), 32'd0);
        tick();
        chk("t6_len0_done_pulse", 32'(done), 32'd0);
        chk("t6_len0_done_once", 32'(n_done - d0), 32'd1);

        // 6b: reset in the middle of an 8-row burst
        for (int i = 200; i < 204; i++) q_addr.push_back((AD+1)'(i));
        q_row.push_back(mem[200]); q_row.push_back(mem[201]);
        d0 = n_done;
        pulse_fetch(200, 8);
        repeat (3) tick();
        row_ready = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b1;
        tick();
        chk("t6_rst_bank_control", 32'(bank_control), 32'd0);
        chk("t6_rst_bank_address", 32'(bank_address), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_row_valid", 32'(row_valid), 32'd0);
        chk("t6_rst_row_data", 32'(row_data), 32'd0);
        tick();
        reset = 1'b0;
        row_ready = 1'b1;
        chk("t6_rst_reads_seen", 32'(q_addr.size()), 32'd0);
        chk("t6_rst_rows_seen", 32'(q_row.size()), 32'd0);
        tick();
        chk("t6_rst_no_done", 32'(n_done - d0), 32'd0);
        exp_burst(300, 3);
        pulse_fetch(300, 3);
        wait_done(20, "t6_after_rst_done", 1'b0);
        tick();
        chk("t6_after_rst_done_once", 32'(n_done - d0), 32'd1);
        chk("t6_after_rst_rows", 32'(q_row.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_weights_bank_sequencer
`default_nettype wire
